// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared types and helpers for the RV32M multiply/divide unit
package muldiv_unit_pkg;

   localparam int XLEN    = 32;
   localparam int XLEN_CW = 6;

   typedef enum logic [2:0] {
      mul    = 3'b000,
      mulh   = 3'b001,
      mulhsu = 3'b010,
      mulhu  = 3'b011,
      div    = 3'b100,
      divu   = 3'b101,
      rem    = 3'b110,
      remu   = 3'b111
   } m_funct3_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } muldiv_state_t;

   // Operand a is treated as two's complement for these ops.
   function automatic logic op_a_signed(m_funct3_t f);
      return (f == mulh) || (f == mulhsu) || (f == div) || (f == rem);
   endfunction

   // Operand b is treated as two's complement for these ops.
   function automatic logic op_b_signed(m_funct3_t f);
      return (f == mulh) || (f == div) || (f == rem);
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - EX-stage request/response bundle for the multiply/divide unit
interface muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       funct3;
   logic [WIDTH-1:0] rs1_data;
   logic [WIDTH-1:0] rs2_data;
   logic             flush;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] result;

   // Pipeline side: issues requests, consumes stall/done/result.
   modport master (
      output start, funct3, rs1_data, rs2_data, flush,
      input  stall, done, result
   );

   // Unit side.
   modport slave (
      input  start, funct3, rs1_data, rs2_data, flush,
      output stall, done, result
   );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with divide fast paths
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = XLEN,
   parameter int CNT_W = XLEN_CW
) (
   input  logic     clk,
   input  logic     rst_n,
   muldiv_if.slave  bus
);

   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

   muldiv_state_t      state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q;
   m_funct3_t          op_q;
   logic               sa_q, sb_q;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               result_load;

   // Request decode in the start cycle.
   m_funct3_t          f3_in;
   logic               accept;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               div_zero, div_ovf, fast;
   logic [WIDTH-1:0]   fast_val;

   assign f3_in    = m_funct3_t'(bus.funct3);
   assign accept   = bus.start && !bus.flush && (state_q == IDLE);
   assign a_neg    = op_a_signed(f3_in) & bus.rs1_data[WIDTH-1];
   assign b_neg    = op_b_signed(f3_in) & bus.rs2_data[WIDTH-1];
   assign a_mag    = a_neg ? -bus.rs1_data : bus.rs1_data;
   assign b_mag    = b_neg ? -bus.rs2_data : bus.rs2_data;
   assign div_zero = (bus.rs2_data == '0);
   assign div_ovf  = ((f3_in == div) || (f3_in == rem)) &&
                     (bus.rs1_data == MIN_INT) && (bus.rs2_data == '1);
   assign fast     = bus.funct3[2] && (div_zero || div_ovf);

   // Divide by zero gives all-ones / dividend; signed overflow gives MIN_INT / 0.
   assign fast_val = div_zero ? (bus.funct3[1] ? bus.rs1_data : '1)
                              : (bus.funct3[1] ? '0 : bus.rs1_data);

   // Shared shift datapath: one iteration of shift-add or restoring divide.
   logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
   logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, mul_res, div_res;

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
   assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                              : {1'b0, acc_q[2*WIDTH-1:1]};

   assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
   assign rem_diff = rem_sh - {1'b0, mcand_q};
   assign div_next = rem_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                     : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   // Sign fix-up applied to the final iteration's value.
   assign prod_fix = (sa_q ^ sb_q) ? -mul_next : mul_next;
   assign mul_res  = (op_q == mul) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
   assign quo_fix  = (sa_q ^ sb_q) ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
   assign rem_fix  = sa_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
   assign div_res  = ((op_q == rem) || (op_q == remu)) ? rem_fix : quo_fix;

   // Next-state, iteration counter and result capture; flush overrides everything.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      result_d    = result_q;
      result_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (fast) begin
                  state_d     = DONE;
                  result_d    = fast_val;
                  result_load = 1'b1;
               end else begin
                  state_d = bus.funct3[2] ? DIV : MUL;
                  cnt_d   = '0;
                  acc_d   = {{WIDTH{1'b0}}, a_mag};
               end
            end
         end
         MUL: begin
            acc_d = mul_next;
            if (cnt_q == LAST_IT) begin
               state_d     = DONE;
               cnt_d       = '0;
               result_d    = mul_res;
               result_load = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DIV: begin
            acc_d = div_next;
            if (cnt_q == LAST_IT) begin
               state_d     = DONE;
               cnt_d       = '0;
               result_d    = div_res;
               result_load = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (bus.flush) begin
         state_d     = IDLE;
         cnt_d       = '0;
         result_load = 1'b0;
      end
   end

   // State, datapath and operand registers; operands latch when a request is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         op_q     <= mul;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         if (accept) begin
            mcand_q <= b_mag;
            op_q    <= f3_in;
            sa_q    <= a_neg;
            sb_q    <= b_neg;
         end
         if (result_load) begin
            result_q <= result_d;
         end
      end
   end

   assign bus.stall  = (accept && rst_n) || (state_q == MUL) || (state_q == DIV);
   assign bus.done   = (state_q == DONE);
   assign bus.result = result_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage. It consumes decoded instructions whose control word has m_enable set.
- Accepts operands and funct3 on a one-cycle start pulse.
- Stalls the pipeline while computing.
- Returns a 32-bit result with a one-cycle done pulse, which the EX result mux selects in place of the ALU output.

Parameters:
WIDTH, 32, operand/result width in bits (RV32M requires 32; other values are unsupported).
CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request; driver is ctrl.m_enable & EX-stage valid.
funct3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
rs1_data  in  WIDTH  operand a.
rs2_data  in  WIDTH  operand b.
flush  in  1  synchronous abort (branch/jump redirect).
stall  out  1  hold the pipeline upstream of EX.
done  out  1  one-cycle pulse; result valid this cycle.
result  out  WIDTH  M-op result.

Behaviour:
- Reset (rst_n low, async): state=IDLE, counter=0, done=0, result=0, all internal registers 0. stall=0 while in reset.
- States:
  - IDLE: start && !flush, with a fast-path case -> DONE. Any other start && !flush -> MUL or DIV by funct3[2].
  - MUL / DIV: after 32 iterations -> DONE.
  - DONE -> IDLE unconditionally.
- stall (combinational) = (start && state==IDLE && !flush) || state==MUL || state==DIV. stall is 0 in DONE so the pipeline advances with the result.
- start is ignored outside IDLE.
- Latency, with the start cycle as cycle 0:
  - normal ops: done=1 in cycle 33;
  - fast paths: done=1 in cycle 1.
- result is registered. It updates only on entry to DONE and holds until the next completion.
- Multiply:
  - Take magnitudes of operands: a is signed for MULH/MULHSU; b is signed for MULH only.
  - Radix-2 shift-add over 32 iterations into a 64-bit accumulator.
  - Negate the 64-bit product if the signs differ.
  - MUL returns the low 32 bits; MULH/MULHSU/MULHU return the high 32 bits.
  - Latch operands and funct3 at start.
- Divide:
  - Signed ops (DIV, REM) use magnitudes; restoring division over 32 iterations with a 33-bit partial remainder.
  - Quotient is negated if sign(a)^sign(b); remainder takes the sign of a.
- Fast paths, resolved in cycle 0 and registered in cycle 1:
  - divisor==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1_data.
  - Signed overflow (DIV/REM with a==0x80000000, b==0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- flush: in any state, the next state is IDLE, the counter clears and no done pulse occurs. result keeps its previous value. flush && start in the same cycle: flush wins and nothing starts.
- Reset mid-operation: returns immediately to IDLE with the reset values above.
- Back-to-back: a start in the cycle after done is accepted normally.

Decomposition:
- Add to rv32i_types:
  - enum m_funct3_t {mul, mulh, mulhsu, mulhu, div, divu, rem, remu};
  - enum muldiv_state_t {IDLE, MUL, DIV, DONE}.
- No sub-module: the FSM and shared shift datapath stay in one module. Sign fix-up is local logic.

Test Plan:
1. MUL rs1=7, rs2=0xFFFFFFFD -> stall 1 in cycles 0..32; done in cycle 33; result=0xFFFFFFEB.
2. MULH 0x80000000 x 0x80000000 -> result 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD at cycle 33. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU -> 2.
4. Edge cases:
   - DIVU 5/0 -> done in cycle 1, result 0xFFFFFFFF.
   - REM 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1.
   - REM same operands -> 0.
5. MUL started, flush in cycle 10 -> stall 0 from cycle 11; no done; result unchanged. A new DIVU 9/3 in cycle 12 -> done in cycle 45, result 3.
6. Reset and back-to-back:
   - rst_n low in cycle 15 of a DIV -> done=0, result=0, stall=0 immediately.
   - After release, two MULs back-to-back (second start in the cycle after the first done) -> both results correct, done pulses 34 cycles apart.
